// File: rtl/riscv_pkg.sv
// Shared fetch-side types: memory FSM states, halfword type, length decode.
package riscv_pkg;

    typedef enum logic [1:0] {
        M_IDLE  = 2'd0,
        M_WAIT  = 2'd1,
        M_DRAIN = 2'd2
    } mem_state_t;

    localparam logic [1:0] OPC_LEN_32 = 2'b11;

    typedef logic [15:0] halfword_t;

    // A halfword starts a 16-bit instruction unless its low opcode bits are 11.
    function automatic logic hw_is_compressed(input halfword_t hw);
        return hw[1:0] != OPC_LEN_32;
    endfunction

endpackage

// File: rtl/halfword_queue.sv
// Three-entry halfword shift queue. Pops are taken from the merged view of
// stored entries followed by this cycle's pushes, so freshly returned data
// can be issued in the same cycle it arrives.
module halfword_queue
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_flush,
    input  logic       i_push0,
    input  halfword_t  i_push0_data,
    input  logic       i_push1,
    input  halfword_t  i_push1_data,
    input  logic       i_pop1,
    input  logic       i_pop2,
    output halfword_t  o_view0,
    output halfword_t  o_view1,
    output logic [2:0] o_avail
);

    halfword_t  r_q [3];
    logic [1:0] r_count;

    halfword_t  w_view [5];
    logic [2:0] w_avail;
    logic [2:0] w_pop_n;
    logic [1:0] w_next_count;

    // Stored entries followed by incoming halfwords (low half first).
    always_comb begin
        w_view[0] = r_q[0];
        w_view[1] = r_q[1];
        w_view[2] = r_q[2];
        w_view[3] = '0;
        w_view[4] = '0;
        w_avail   = {1'b0, r_count};
        if (i_push0) begin
            w_view[w_avail] = i_push0_data;
            w_avail         = w_avail + 3'd1;
        end
        if (i_push1) begin
            w_view[w_avail] = i_push1_data;
            w_avail         = w_avail + 3'd1;
        end
    end

    assign w_pop_n      = i_pop2 ? 3'd2 : (i_pop1 ? 3'd1 : 3'd0);
    assign w_next_count = 2'(w_avail - w_pop_n);

    // Shift out popped entries and store what remains of the merged view.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_count <= '0;
            r_q     <= '{default: '0};
        end else begin
            r_count <= w_next_count;
            r_q[0]  <= w_view[w_pop_n];
            r_q[1]  <= w_view[w_pop_n + 3'd1];
            r_q[2]  <= w_view[w_pop_n + 3'd2];
        end
    end

    assign o_view0 = w_view[0];
    assign o_view1 = w_view[1];
    assign o_avail = w_avail;

endmodule

// File: rtl/inst_fetch_aligner.sv
// Fetch sequencer and RV32IC realigner: issues word reads, buffers halfwords,
// and hands one 16- or 32-bit instruction per handshake to decode.
module inst_fetch_aligner
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_raw,
    output logic        inst_is_c,
    output logic [31:0] inst_pc
);

    mem_state_t  r_state, w_state_next;
    logic [31:0] r_fetch_addr;
    logic [31:0] r_issue_pc;
    logic        r_skip_lo;
    logic        r_inst_valid;
    logic        r_inst_is_c;
    logic [31:0] r_inst_raw;
    logic [31:0] r_inst_pc;

    halfword_t   w_view0, w_view1;
    logic [2:0]  w_avail;
    logic [2:0]  w_avail_after_pop;
    logic        w_head_c, w_issuable, w_slot_free, w_issue;
    logic        w_pop1, w_pop2;
    logic        w_rsp, w_push0, w_push1;
    logic        w_req;
    logic        w_unused_pc0;

    assign w_unused_pc0 = redirect_pc[0];

    // A response is only consumed in M_WAIT and never on a redirect cycle.
    assign w_rsp   = (r_state == M_WAIT) && imem_rvalid;
    assign w_push1 = w_rsp && !redirect_valid;
    assign w_push0 = w_push1 && !r_skip_lo;

    halfword_queue u_queue (
        .clk          (clk),
        .rst          (rst),
        .i_flush      (redirect_valid),
        .i_push0      (w_push0),
        .i_push0_data (imem_rdata[15:0]),
        .i_push1      (w_push1),
        .i_push1_data (imem_rdata[31:16]),
        .i_pop1       (w_pop1),
        .i_pop2       (w_pop2),
        .o_view0      (w_view0),
        .o_view1      (w_view1),
        .o_avail      (w_avail)
    );

    // Issue decision: head length, availability and output slot.
    always_comb begin
        w_head_c          = hw_is_compressed(w_view0);
        w_issuable        = (w_avail != 3'd0) && (w_head_c || (w_avail >= 3'd2));
        w_slot_free       = !r_inst_valid || inst_ready;
        w_issue           = w_issuable && w_slot_free && !redirect_valid;
        w_pop1            = w_issue && w_head_c;
        w_pop2            = w_issue && !w_head_c;
        w_avail_after_pop = w_avail - (w_pop2 ? 3'd2 : (w_pop1 ? 3'd1 : 3'd0));
    end

    // Memory FSM next state and request strobe.
    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        case (r_state)
            M_IDLE: begin
                if (!rst && !redirect_valid && (w_avail_after_pop <= 3'd1)) begin
                    w_req        = 1'b1;
                    w_state_next = M_WAIT;
                end
            end
            M_WAIT: begin
                if (imem_rvalid)
                    w_state_next = M_IDLE;
                else if (redirect_valid)
                    w_state_next = M_DRAIN;
            end
            M_DRAIN: begin
                if (imem_rvalid)
                    w_state_next = M_IDLE;
            end
            default: w_state_next = M_IDLE;
        endcase
    end

    // Memory FSM state register.
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= M_IDLE;
        else
            r_state <= w_state_next;
    end

    // Fetch/issue pointers and the registered output slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_addr <= {RESET_PC[31:2], 2'b00};
            r_skip_lo    <= RESET_PC[1];
            r_issue_pc   <= {RESET_PC[31:1], 1'b0};
            r_inst_valid <= 1'b0;
            r_inst_raw   <= '0;
            r_inst_is_c  <= 1'b0;
            r_inst_pc    <= RESET_PC;
        end else if (redirect_valid) begin
            r_fetch_addr <= {redirect_pc[31:2], 2'b00};
            r_skip_lo    <= redirect_pc[1];
            r_issue_pc   <= {redirect_pc[31:1], 1'b0};
            r_inst_valid <= 1'b0;
        end else begin
            if (w_rsp) begin
                r_fetch_addr <= r_fetch_addr + 32'd4;
                r_skip_lo    <= 1'b0;
            end
            if (w_issue) begin
                r_inst_valid <= 1'b1;
                r_inst_raw   <= w_head_c ? {16'h0000, w_view0} : {w_view1, w_view0};
                r_inst_is_c  <= w_head_c;
                r_inst_pc    <= r_issue_pc;
                r_issue_pc   <= r_issue_pc + (w_head_c ? 32'd2 : 32'd4);
            end else if (inst_ready) begin
                r_inst_valid <= 1'b0;
            end
        end
    end

    assign imem_req   = w_req;
    assign imem_addr  = r_fetch_addr;
    assign inst_valid = r_inst_valid;
    assign inst_raw   = r_inst_raw;
    assign inst_is_c  = r_inst_is_c;
    assign inst_pc    = r_inst_pc;

endmodule

// File: tb/tb_inst_fetch_aligner.sv
// Scoreboard bench for inst_fetch_aligner with a latency-programmable memory.
module tb_inst_fetch_aligner;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_raw;
    logic        inst_is_c;
    logic [31:0] inst_pc;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] raw;
        logic        c;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] req_log[$];
    logic [31:0] mem [logic [31:0]];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          mem_lat  = 1;
    int          mem_cnt  = 0;
    bit          mem_pend = 1'b0;
    bit          mem_inject = 1'b0;
    logic [31:0] mem_paddr = '0;
    bit          tb_ready = 1'b1;

    always #5 clk = ~clk;

    inst_fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_raw       (inst_raw),
        .inst_is_c      (inst_is_c),
        .inst_pc        (inst_pc)
    );

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a))
            return mem[a];
        return 32'h0001_0001;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] raw, input logic c);
        exp_t e;
        e.pc  = pc;
        e.raw = raw;
        e.c   = c;
        exp_q.push_back(e);
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    // Returns at the negedge of the cycle that carries imem_req.
    task automatic wait_req(input string name, output logic [31:0] addr);
        bit seen;
        seen = 1'b0;
        addr = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (imem_req) begin
                seen = 1'b1;
                addr = imem_addr;
                break;
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no imem_req within 60 cycles", name);
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0)
                break;
            tick();
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: %0d instructions never issued", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Memory: sample requests at negedge.
    initial begin
        forever begin
            @(negedge clk);
            if (imem_req && !rst) begin
                req_log.push_back(imem_addr);
                mem_pend  = 1'b1;
                mem_cnt   = mem_lat;
                mem_paddr = imem_addr;
            end
        end
    end

    // Memory: drive responses shortly after posedge.
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(posedge clk);
            #2;
            imem_rvalid = 1'b0;
            if (rst)
                mem_pend = 1'b0;
            if (mem_inject) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'h1111_1111;
                mem_inject  = 1'b0;
            end else if (mem_pend) begin
                mem_cnt--;
                if (mem_cnt <= 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_rd(mem_paddr);
                    mem_pend    = 1'b0;
                end
            end
        end
    end

    // Downstream accepts only while instructions are still expected.
    initial begin
        inst_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            inst_ready = tb_ready && (exp_q.size() != 0);
        end
    end

    // Monitor: pop and compare on each handshake; a stalled slot must show the next expected one.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && inst_valid && inst_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: pc=%h raw=%h c=%0b", inst_pc, inst_raw, inst_is_c);
                end else begin
                    e = exp_q.pop_front();
                    if (inst_pc !== e.pc || inst_raw !== e.raw || inst_is_c !== e.c) begin
                        n_fail++;
                        $display("FAIL sb_inst: got pc=%h raw=%h c=%0b expected pc=%h raw=%h c=%0b",
                                 inst_pc, inst_raw, inst_is_c, e.pc, e.raw, e.c);
                    end
                end
            end else if (!rst && !redirect_valid && inst_valid && !inst_ready && exp_q.size() != 0) begin
                e = exp_q[0];
                n_checks++;
                if (inst_pc !== e.pc || inst_raw !== e.raw || inst_is_c !== e.c) begin
                    n_fail++;
                    $display("FAIL hold: got pc=%h raw=%h c=%0b expected pc=%h raw=%h c=%0b",
                             inst_pc, inst_raw, inst_is_c, e.pc, e.raw, e.c);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          mark;
        int          n;

        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        mem[32'h0000_0000] = 32'h4501_4581;
        mem[32'h0000_0040] = 32'h0093_4505;
        mem[32'h0000_0044] = 32'h0001_0010;
        mem[32'h0000_0100] = 32'h4585_FFFF;
        mem[32'h0000_0200] = 32'h1111_1111;
        mem[32'h0000_0300] = 32'h4789_4709;
        mem[32'h0000_0400] = 32'h4685_4681;
        mem[32'h0000_0404] = 32'h4705_4701;
        mem[32'h0000_0408] = 32'h0050_0513;
        mem[32'h0000_040C] = 32'h4605_4601;
        mem[32'h0000_0500] = 32'h1111_1111;
        mem[32'h0000_0600] = 32'h4B05_4B01;
        mem[32'h0000_0700] = 32'h1111_1111;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_imem_req",   32'(imem_req),   32'd0);
        chk("rst_imem_addr",  imem_addr,       32'h0000_0000);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst_raw",   inst_raw,        32'h0000_0000);
        chk("rst_inst_is_c",  32'(inst_is_c),  32'd0);
        chk("rst_inst_pc",    inst_pc,         32'h0000_0000);

        // Two compressed instructions from one word
        push_exp(32'h0, 32'h0000_4581, 1'b1);
        push_exp(32'h2, 32'h0000_4501, 1'b1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("first_req",      32'(imem_req),   32'd1);
        chk("first_req_addr", imem_addr,       32'h0000_0000);
        @(negedge clk);
        chk("rvalid_not_yet_valid", 32'(inst_valid), 32'd0);
        @(negedge clk);
        chk("latency_valid", 32'(inst_valid), 32'd1);
        wait_drain("t1_drain");
        n = 0;
        foreach (req_log[i]) if (req_log[i] == 32'h0) n++;
        chk("t1_reqs_to_word0", 32'(n), 32'd1);

        // 32-bit instruction split across a word boundary
        do_redirect(32'h40);
        push_exp(32'h40, 32'h0000_4505, 1'b1);
        push_exp(32'h42, 32'h0010_0093, 1'b0);
        push_exp(32'h46, 32'h0000_0001, 1'b1);
        wait_drain("t2_drain");

        // Odd-halfword redirect target
        do_redirect(32'h102);
        mark = req_log.size();
        push_exp(32'h102, 32'h0000_4585, 1'b1);
        push_exp(32'h104, 32'h0000_0001, 1'b1);
        wait_drain("t3_drain");
        chk("t3_req_addr", (req_log.size() > mark) ? req_log[mark] : 32'hFFFF_FFFF, 32'h0000_0100);

        // Redirect while a read is outstanding; stale data arrives 3 cycles after the request
        mem_lat = 3;
        do_redirect(32'h200);
        wait_req("t4_req", a);
        chk("t4_req_addr", a, 32'h0000_0200);
        do_redirect(32'h300);
        mark = req_log.size();
        push_exp(32'h300, 32'h0000_4709, 1'b1);
        push_exp(32'h302, 32'h0000_4789, 1'b1);
        wait_drain("t4_drain");
        chk("t4_next_req_addr", (req_log.size() > mark) ? req_log[mark] : 32'hFFFF_FFFF, 32'h0000_0300);

        // Back-pressure for 5 cycles in the middle of a stream
        mem_lat = 1;
        do_redirect(32'h400);
        push_exp(32'h400, 32'h0000_4681, 1'b1);
        push_exp(32'h402, 32'h0000_4685, 1'b1);
        push_exp(32'h404, 32'h0000_4701, 1'b1);
        push_exp(32'h406, 32'h0000_4705, 1'b1);
        push_exp(32'h408, 32'h0050_0513, 1'b0);
        push_exp(32'h40C, 32'h0000_4601, 1'b1);
        push_exp(32'h40E, 32'h0000_4605, 1'b1);
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() <= 5)
                break;
            tick();
        end
        tb_ready = 1'b0;
        tick();
        mark = req_log.size();
        repeat (5) tick();
        n = req_log.size() - mark;
        n_checks++;
        if (n > 1) begin
            n_fail++;
            $display("FAIL stall_fetches: got %0d fetches during stall, allowed at most 1", n);
        end
        tb_ready = 1'b1;
        wait_drain("t5_drain");

        // Redirect in the same cycle as the response
        mem_lat = 2;
        do_redirect(32'h500);
        wait_req("t6_req", a);
        chk("t6_req_addr", a, 32'h0000_0500);
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h600;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("t6_fresh_req",      32'(imem_req), 32'd1);
        chk("t6_fresh_req_addr", imem_addr,     32'h0000_0600);
        push_exp(32'h600, 32'h0000_4B01, 1'b1);
        push_exp(32'h602, 32'h0000_4B05, 1'b1);
        wait_drain("t6_drain");

        // Reset while waiting; stale response lands during reset
        mem_lat = 3;
        do_redirect(32'h700);
        wait_req("t7_req", a);
        chk("t7_req_addr", a, 32'h0000_0700);
        tick();
        rst = 1'b1;
        tick();
        mem_inject = 1'b1;
        @(negedge clk);
        chk("t7_rst_valid", 32'(inst_valid), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t7_fresh_req",      32'(imem_req), 32'd1);
        chk("t7_fresh_req_addr", imem_addr,     32'h0000_0000);
        push_exp(32'h0, 32'h0000_4581, 1'b1);
        push_exp(32'h2, 32'h0000_4501, 1'b1);
        wait_drain("t7_drain");

        repeat (5) tick();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
